// File: rtl/simon_round_ctrl.sv
// Simon-style round controller: shows a growing color sequence, then checks the player's presses.
// Optional player-input timeout is enabled by defining SIMON_TIMEOUT_EN.
module simon_round_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pattern_in,
  input  logic        btn_valid,
  input  logic [1:0]  btn_color,
  output logic        led_on,
  output logic [1:0]  led_color,
  output logic        busy,
  output logic        win,
  output logic        lose,
  output logic [3:0]  round
);

  localparam int unsigned PAT_W    = 16;
  localparam int unsigned RND_W    = 4;
  localparam int unsigned MAX_RND  = 8;
  localparam int unsigned MAX_SG   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned MAX_CNT  = (TIMEOUT_CYCLES > MAX_SG) ? TIMEOUT_CYCLES : MAX_SG;
`else
  // The timeout length deliberately contributes nothing to counter sizing here.
  localparam int unsigned MAX_CNT  = MAX_SG + 0 * TIMEOUT_CYCLES;
`endif
  localparam int unsigned CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(MAX_RND);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ON,
    ST_SHOW_GAP,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] work_q, work_d;
  logic [RND_W-1:0] index_q, index_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_on_q, led_on_d;
  logic [1:0]       led_color_q, led_color_d;
  logic             busy_q, busy_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;

  logic             last_step;

  assign last_step = ((index_q + RND_W'(1)) == round_q);

  // Next-state logic; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    work_d    = work_q;
    index_d   = index_q;
    round_d   = round_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          pattern_d = pattern_in;
          work_d    = pattern_in;
          round_d   = RND_W'(1);
          index_d   = '0;
          cnt_d     = '0;
          state_d   = ST_SHOW_ON;
        end
      end

      ST_SHOW_ON: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHOW_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (last_step) begin
            work_d  = pattern_q;
            index_d = '0;
            state_d = ST_WAIT_IN;
          end else begin
            work_d  = work_q >> 2;
            index_d = index_q + RND_W'(1);
            state_d = ST_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_IN: begin
        if (btn_valid) begin
          cnt_d = '0;
          if (btn_color == work_q[1:0]) begin
            if (!last_step) begin
              work_d  = work_q >> 2;
              index_d = index_q + RND_W'(1);
            end else if (round_q == RND_LAST) begin
              index_d = index_q + RND_W'(1);
              state_d = ST_WIN;
            end else begin
              round_d = round_q + RND_W'(1);
              work_d  = pattern_q;
              index_d = '0;
              state_d = ST_SHOW_ON;
            end
          end else begin
            state_d = ST_LOSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    led_on_d    = (state_d == ST_SHOW_ON);
    led_color_d = led_on_d ? work_d[1:0] : 2'b00;
    busy_d      = (state_d == ST_SHOW_ON) || (state_d == ST_SHOW_GAP) || (state_d == ST_WAIT_IN);
    win_d       = (state_d == ST_WIN);
    lose_d      = (state_d == ST_LOSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      work_q      <= '0;
      index_q     <= '0;
      round_q     <= '0;
      cnt_q       <= '0;
      led_on_q    <= 1'b0;
      led_color_q <= 2'b00;
      busy_q      <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      work_q      <= work_d;
      index_q     <= index_d;
      round_q     <= round_d;
      cnt_q       <= cnt_d;
      led_on_q    <= led_on_d;
      led_color_q <= led_color_d;
      busy_q      <= busy_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign led_on    = led_on_q;
  assign led_color = led_color_q;
  assign busy      = busy_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign round     = round_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed self-checking bench for simon_round_ctrl (default parameters).
module tb_simon_round_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern_in;
  logic        btn_valid;
  logic [1:0]  btn_color;
  logic        led_on;
  logic [1:0]  led_color;
  logic        busy;
  logic        win;
  logic        lose;
  logic [3:0]  round;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simon_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern_in (pattern_in),
    .btn_valid  (btn_valid),
    .btn_color  (btn_color),
    .led_on     (led_on),
    .led_color  (led_color),
    .busy       (busy),
    .win        (win),
    .lose       (lose),
    .round      (round)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    tick();
    btn_valid = 1'b0;
  endtask

  // Called on the first lit cycle: 4 lit cycles of color c, then 2 dark cycles.
  task automatic expect_show(input logic [1:0] c);
    for (int i = 0; i < 4; i++) begin
      check_eq("show_led_on", 32'(led_on), 32'd1);
      check_eq("show_color", 32'(led_color), 32'(c));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("gap_led_on", 32'(led_on), 32'd0);
      check_eq("gap_color", 32'(led_color), 32'd0);
      check_eq("gap_busy", 32'(busy), 32'd1);
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; pattern_in = '0; btn_valid = 1'b0; btn_color = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_led_on", 32'(led_on), 32'd0);
    check_eq("rst_color", 32'(led_color), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_win", 32'(win), 32'd0);
    check_eq("rst_lose", 32'(lose), 32'd0);
    check_eq("rst_round", 32'(round), 32'd0);

    // Reset held two cycles in the middle of SHOW_ON aborts the game.
    pattern_in = 16'h00E4;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check_eq("mid_led_on", 32'(led_on), 32'd1);
    do_reset();
    check_eq("abort_led_on", 32'(led_on), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_round", 32'(round), 32'd0);
    check_eq("abort_win", 32'(win), 32'd0);
    check_eq("abort_lose", 32'(lose), 32'd0);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    check_eq("rst_prio_busy", 32'(busy), 32'd0);
    check_eq("rst_prio_round", 32'(round), 32'd0);

    // Pattern E4 = colors 0,1,2,3,0,0,0,0.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("r1_round", 32'(round), 32'd1);
    check_eq("r1_busy", 32'(busy), 32'd1);
    expect_show(2'd0);
    check_eq("r1_wait_led", 32'(led_on), 32'd0);
    check_eq("r1_wait_busy", 32'(busy), 32'd1);
    check_eq("r1_wait_round", 32'(round), 32'd1);
    press(2'd0);
    check_eq("r2_round", 32'(round), 32'd2);
    expect_show(2'd0);
    expect_show(2'd1);
    check_eq("r2_wait_led", 32'(led_on), 32'd0);
    press(2'd0);
    check_eq("r2_mid_round", 32'(round), 32'd2);
    check_eq("r2_mid_led", 32'(led_on), 32'd0);
    press(2'd1);
    check_eq("r3_round", 32'(round), 32'd3);
    check_eq("r3_led_on", 32'(led_on), 32'd1);
    check_eq("r3_color", 32'(led_color), 32'd0);

    // Start during SHOW_ON is ignored: the stored pattern must not change.
    pattern_in = 16'hFFFF;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("ign_start_round", 32'(round), 32'd3);
    check_eq("ign_start_color", 32'(led_color), 32'd0);
    do_reset();

    // Losing game, including start+press together in WAIT_IN.
    pattern_in = 16'h00E4;
    start = 1'b1; tick(); start = 1'b0;
    expect_show(2'd0);
    press(2'd0);
    expect_show(2'd0);
    expect_show(2'd1);
    start = 1'b1; btn_valid = 1'b1; btn_color = 2'd0;
    tick();
    start = 1'b0; btn_valid = 1'b0;
    check_eq("both_round", 32'(round), 32'd2);
    check_eq("both_busy", 32'(busy), 32'd1);
    check_eq("both_led", 32'(led_on), 32'd0);
    press(2'd2);
    check_eq("lose_lose", 32'(lose), 32'd1);
    check_eq("lose_win", 32'(win), 32'd0);
    check_eq("lose_busy", 32'(busy), 32'd0);
    check_eq("lose_round", 32'(round), 32'd2);
    press(2'd1);
    tick();
    check_eq("lose_hold", 32'(lose), 32'd1);
    check_eq("lose_hold_round", 32'(round), 32'd2);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("restart_lose", 32'(lose), 32'd0);
    check_eq("restart_round", 32'(round), 32'd1);
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_led", 32'(led_on), 32'd1);
    do_reset();

    // All-zero pattern played to a win; a press during SHOW_ON must be ignored.
    pattern_in = 16'h0000;
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      for (int i = 0; i < 6 * r; i++) begin
        if (r == 1 && i == 0) begin
          btn_valid = 1'b1;
          btn_color = 2'd0;
        end
        tick();
        btn_valid = 1'b0;
        if (r == 1 && i == 0) begin
          check_eq("show_press_led", 32'(led_on), 32'd1);
          check_eq("show_press_round", 32'(round), 32'd1);
        end
      end
      check_eq("win_wait_led", 32'(led_on), 32'd0);
      check_eq("win_wait_busy", 32'(busy), 32'd1);
      check_eq("win_wait_round", 32'(round), 32'(r));
      for (int p = 0; p < r; p++) press(2'd0);
      if (r < 8) check_eq("win_next_round", 32'(round), 32'(r + 1));
    end
    check_eq("win_win", 32'(win), 32'd1);
    check_eq("win_lose", 32'(lose), 32'd0);
    check_eq("win_busy", 32'(busy), 32'd0);
    check_eq("win_round", 32'(round), 32'd8);
    check_eq("win_led", 32'(led_on), 32'd0);
    press(2'd1);
    tick();
    check_eq("win_hold", 32'(win), 32'd1);
    check_eq("win_hold_lose", 32'(lose), 32'd0);
    do_reset();

    // Idle player in WAIT_IN.
    pattern_in = 16'h00E4;
    start = 1'b1; tick(); start = 1'b0;
    expect_show(2'd0);
`ifdef SIMON_TIMEOUT_EN
    repeat (15) tick();
    check_eq("to_pre_lose", 32'(lose), 32'd0);
    check_eq("to_pre_busy", 32'(busy), 32'd1);
    tick();
    check_eq("to_lose", 32'(lose), 32'd1);
    check_eq("to_busy", 32'(busy), 32'd0);
    check_eq("to_round", 32'(round), 32'd1);
`else
    repeat (100) tick();
    check_eq("idle_busy", 32'(busy), 32'd1);
    check_eq("idle_lose", 32'(lose), 32'd0);
    press(2'd0);
    check_eq("idle_press_round", 32'(round), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simon_round_ctrl.md
SIMON_ROUND_CTRL -- requirements
Module: simon_round_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 4, clock cycles each pattern color is lit.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, dark cycles after each lit color.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, player-input timeout; used only when SIMON_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a game.
REQ-007 SHALL have port pattern_in, input, 16, eight 2-bit colors; color k is bits [2k+1:2k].
REQ-008 SHALL have port btn_valid, input, 1, single-cycle player press strobe.
REQ-009 SHALL have port btn_color, input, 2, color pressed, qualified by btn_valid.
REQ-010 SHALL have port led_on, output, 1, pattern LED enable.
REQ-011 SHALL have port led_color, output, 2, color being shown; 0 when led_on=0.
REQ-012 SHALL have port busy, output, 1, game in progress (any state except IDLE, WIN, LOSE).
REQ-013 SHALL have port win, output, 1, level; all 8 rounds completed.
REQ-014 SHALL have port lose, output, 1, level; wrong press or timeout.
REQ-015 SHALL have port round, output, 4, current round length, 1..8; 0 in IDLE.

Function
REQ-016 SHALL implement the states IDLE, SHOW_ON, SHOW_GAP, WAIT_IN, WIN and LOSE.
REQ-017 On start in IDLE, WIN or LOSE: latch pattern_in into the stored pattern and a working shift copy, set round=1 and index=0, clear win/lose, go to SHOW_ON next cycle; start in any other state is ignored.
REQ-018 SHOW_ON: led_on=1 and led_color=working[1:0] for exactly SHOW_CYCLES cycles, then go to SHOW_GAP.
REQ-019 SHOW_GAP: led_on=0 for exactly GAP_CYCLES cycles; on exit, shift working right by 2 and increment index.
REQ-020 On SHOW_GAP exit with index==round: reload working from the stored pattern, set index=0, go to WAIT_IN; otherwise return to SHOW_ON.
REQ-021 btn_valid SHALL be ignored in every state except WAIT_IN.
REQ-022 In WAIT_IN, on btn_valid with btn_color==working[1:0]: shift working right by 2 and increment index.
REQ-023 A matching press that makes index==round SHALL complete the round: at round==8 go to WIN; otherwise increment round, reload working, set index=0, go to SHOW_ON.
REQ-024 In WAIT_IN, btn_valid with a mismatching btn_color SHALL go to LOSE.
REQ-025 Player input latency SHALL be one cycle: state and flag outputs reflect a press on the cycle after btn_valid.
REQ-026 win and lose SHALL be registered, mutually exclusive, held until start or reset; round SHALL hold its final value in WIN and LOSE.
REQ-027 start and btn_valid asserted together in WAIT_IN: start is ignored and the press is processed.
REQ-028 Cycle counters SHALL be sized $clog2 of the largest count used and reset to 0 on every state entry.

Reset
REQ-029 reset SHALL force IDLE, clear the stored pattern, working copy, index and counters, and set led_on=0, led_color=0, busy=0, win=0, lose=0, round=0 on the next edge.
REQ-030 reset SHALL take priority over start and btn_valid and SHALL abort a game in any state.

Configuration
REQ-031 With SIMON_TIMEOUT_EN defined: in WAIT_IN, TIMEOUT_CYCLES consecutive cycles without btn_valid SHALL go to LOSE; each accepted matching press restarts the count.
REQ-032 With SIMON_TIMEOUT_EN undefined: WAIT_IN SHALL wait indefinitely, the timeout counter SHALL be absent, and TIMEOUT_CYCLES SHALL have no effect.

Verification
REQ-033 reset held 2 cycles mid-SHOW_ON -> next cycle IDLE, led_on=0, busy=0, round=0, win=0, lose=0.
REQ-034 pattern_in=16'hE4, start -> led_on=1 with color 0 for 4 cycles, led_on=0 for 2 cycles, then WAIT_IN with round=1.
REQ-035 Same game, press 0 in round 1 -> round=2, sequence 0,1 shown; presses 0,1 -> round=3.
REQ-036 Round 2, press 0 then 2 -> lose=1 next cycle, busy=0, round=2; a later start clears lose and restarts at round=1.
REQ-037 pattern_in=16'h0000, correct presses through round 8 -> win=1, round=8; btn_valid pressed during SHOW_ON is ignored.
REQ-038 SIMON_TIMEOUT_EN defined, no press for 16 cycles in WAIT_IN -> lose=1; with the macro undefined, 100 idle cycles -> still busy=1.
